// File: rtl/ssc_port_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssc_port_pkg
// Purpose  : Shared definitions for the SSC port sequencer: sequencer state
//            encoding, downstream port index map and small helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ssc_port_pkg;

  // Sequencer states; 3 bits hold all five states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ARMED  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HOLD   = 3'd4
  } seq_state_t;

  // Number of physical ports behind the SSC mux.
  localparam int SSC_NUM_PORTS = 25;

  // Port index map: each cartridge band owns a WCA port followed by a BIAS port.
  localparam logic [4:0] PORT_B1_WCA     = 5'd0;
  localparam logic [4:0] PORT_B1_BIAS    = 5'd1;
  localparam logic [4:0] PORT_B2_WCA     = 5'd2;
  localparam logic [4:0] PORT_B2_BIAS    = 5'd3;
  localparam logic [4:0] PORT_B3_WCA     = 5'd4;
  localparam logic [4:0] PORT_B3_BIAS    = 5'd5;
  localparam logic [4:0] PORT_B4_WCA     = 5'd6;
  localparam logic [4:0] PORT_B4_BIAS    = 5'd7;
  localparam logic [4:0] PORT_B5_WCA     = 5'd8;
  localparam logic [4:0] PORT_B5_BIAS    = 5'd9;
  localparam logic [4:0] PORT_B6_WCA     = 5'd10;
  localparam logic [4:0] PORT_B6_BIAS    = 5'd11;
  localparam logic [4:0] PORT_B7_WCA     = 5'd12;
  localparam logic [4:0] PORT_B7_BIAS    = 5'd13;
  localparam logic [4:0] PORT_B8_WCA     = 5'd14;
  localparam logic [4:0] PORT_B8_BIAS    = 5'd15;
  localparam logic [4:0] PORT_B9_WCA     = 5'd16;
  localparam logic [4:0] PORT_B9_BIAS    = 5'd17;
  localparam logic [4:0] PORT_B10_WCA    = 5'd18;
  localparam logic [4:0] PORT_B10_BIAS   = 5'd19;
  localparam logic [4:0] PORT_POWER_DIST = 5'd20;
  localparam logic [4:0] PORT_IF_SWITCH  = 5'd21;
  localparam logic [4:0] PORT_CRYOSTAT   = 5'd22;
  localparam logic [4:0] PORT_LOPR       = 5'd23;
  localparam logic [4:0] PORT_SPARE      = 5'd24;

  // Larger of two integers, used to size the shared interval counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : ssc_port_pkg
`default_nettype wire

// File: rtl/ssc_port_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for an asynchronous level. Resets to 1 so
//            an idle-high sync line does not produce a false falling edge
//            when reset is released.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/ssc_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ssc_port_sequencer
// Purpose  : Owns the SSC port mux select. Accepts one port request at a
//            time, waits a settle interval after a select change, grants the
//            bus, then freezes the select for the SSC frame plus a hold time.
// Config   : SSC_PORT_SEQ_TIMEOUT_EN - when defined, ARMED gives up after
//            TIMEOUT_CYCLES without a frame start and pulses errTimeout.
// Revision : 1.0 - initial release
// ============================================================================
module ssc_port_sequencer
  import ssc_port_pkg::*;
#(
  parameter int NUM_PORTS      = SSC_NUM_PORTS,
  parameter int PARK_PORT      = int'(PORT_SPARE),
  parameter int SETTLE_CYCLES  = 8,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       reqValid,
  input  logic [4:0] reqPort,
  output logic       reqReady,
  input  logic       sscSync1,
  output logic [4:0] sscPort,
  output logic       grant,
  output logic       done,
  output logic       errInvalid,
  output logic       errTimeout,
  output logic       busy
);

  // One counter serves settle, hold and (optionally) timeout intervals.
  localparam int CNT_MAX = max_int(max_int(SETTLE_CYCLES, HOLD_CYCLES), TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters are loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [4:0]       PARK_SEL    = 5'(PARK_PORT);

`ifdef SSC_PORT_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_timeout_q;
`endif

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             sync_s;
  logic             sync_prev;
  logic             frame_start;
  logic             req_invalid;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rstN),
    .din   (sscSync1),
    .dout  (sync_s)
  );

  // Edge register: remembers the previous synchronized sync level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_prev <= 1'b1;
    end else begin
      sync_prev <= sync_s;
    end
  end

  // A frame starts on a 1->0 of the synchronized sync; a line that is
  // already low when ARMED is entered has sync_prev low and is not a start.
  assign frame_start = sync_prev & ~sync_s;
  assign req_invalid = int'(reqPort) >= NUM_PORTS;

  // Sequencer FSM; the select and all pulses are registered here.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= ST_IDLE;
      sscPort    <= PARK_SEL;
      reqReady   <= 1'b1;
      grant      <= 1'b0;
      done       <= 1'b0;
      errInvalid <= 1'b0;
      cnt        <= CNT_ZERO;
`ifdef SSC_PORT_SEQ_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      grant      <= 1'b0;
      done       <= 1'b0;
      errInvalid <= 1'b0;
`ifdef SSC_PORT_SEQ_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (reqValid && reqReady) begin
            if (req_invalid) begin
              errInvalid <= 1'b1;
            end else if (reqPort == sscPort) begin
              // Mux already points there: nothing to settle.
              state    <= ST_ARMED;
              grant    <= 1'b1;
              reqReady <= 1'b0;
              cnt      <= CNT_ZERO;
            end else begin
              sscPort  <= reqPort;
              cnt      <= SETTLE_LOAD;
              state    <= ST_SETTLE;
              reqReady <= 1'b0;
            end
          end
        end

        ST_SETTLE: begin
          if (cnt == CNT_ZERO) begin
            state <= ST_ARMED;
            grant <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_ARMED: begin
          if (frame_start) begin
            state <= ST_ACTIVE;
            cnt   <= CNT_ZERO;
          end
`ifdef SSC_PORT_SEQ_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            err_timeout_q <= 1'b1;
            state         <= ST_IDLE;
            reqReady      <= 1'b1;
            cnt           <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end

        ST_ACTIVE: begin
          if (sync_s) begin
            cnt   <= HOLD_LOAD;
            state <= ST_HOLD;
            done  <= (HOLD_CYCLES == 1);
          end
        end

        ST_HOLD: begin
          if (cnt == CNT_ZERO) begin
            state    <= ST_IDLE;
            reqReady <= 1'b1;
          end else begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
          end
        end

        default: begin
          state    <= ST_IDLE;
          reqReady <= 1'b1;
        end
      endcase
    end
  end

`ifdef SSC_PORT_SEQ_TIMEOUT_EN
  assign errTimeout = err_timeout_q;
`else
  assign errTimeout = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule : ssc_port_sequencer
`default_nettype wire

// File: tb/tb_ssc_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssc_port_sequencer
// Purpose  : Self-checking bench for ssc_port_sequencer. Pulses seen on the
//            outputs are collected as events and matched against expected
//            events (kind, cycle, select) queued when stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssc_port_sequencer;
  import ssc_port_pkg::*;

  localparam int SETTLE = 8;
  localparam int HOLD   = 4;
  localparam int TMO    = 16;

  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_INV   = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [4:0]  port;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       reqValid = 1'b0;
  logic [4:0] reqPort = 5'd0;
  logic       sscSync1 = 1'b1;
  logic       reqReady;
  logic [4:0] sscPort;
  logic       grant;
  logic       done;
  logic       errInvalid;
  logic       errTimeout;
  logic       busy;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  ssc_port_sequencer #(
    .NUM_PORTS      (25),
    .PARK_PORT      (24),
    .SETTLE_CYCLES  (SETTLE),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqValid   (reqValid),
    .reqPort    (reqPort),
    .reqReady   (reqReady),
    .sscSync1   (sscSync1),
    .sscPort    (sscPort),
    .grant      (grant),
    .done       (done),
    .errInvalid (errInvalid),
    .errTimeout (errTimeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [1:0] k, input int c, input logic [4:0] p);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.port = p;
    return e;
  endfunction

  // Monitor: record every output pulse with its cycle and the select value.
  always @(negedge clk) begin
    if (rstN) begin
      if (grant)      obs_q.push_back(mk(K_GRANT, cyc, sscPort));
      if (done)       obs_q.push_back(mk(K_DONE,  cyc, sscPort));
      if (errInvalid) obs_q.push_back(mk(K_INV,   cyc, sscPort));
      if (errTimeout) obs_q.push_back(mk(K_TMO,   cyc, sscPort));
    end
  end

  // Bounded wait for the next observed event.
  task automatic wait_event(output ev_t e, output bit got);
    got = 1'b0;
    e   = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) begin
        e   = obs_q.pop_front();
        got = 1'b1;
      end
    end
  endtask

  // Present a request once the DUT is ready; c is the cycle before the accept edge.
  task automatic do_request(input logic [4:0] p, output int c);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (reqReady) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL req_ready_wait: reqReady=%0b required 1", reqReady);
    else n_pass++;
    reqValid = 1'b1;
    reqPort  = p;
    c        = cyc;
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Drive one SSC frame and queue the expected done pulse.
  task automatic drive_frame(input int low_cycles, input logic [4:0] p);
    @(negedge clk);
    sscSync1 = 1'b0;
    repeat (low_cycles) @(negedge clk);
    sscSync1 = 1'b1;
    exp_q.push_back(mk(K_DONE, cyc + 2 + HOLD, p));
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sscPort !== 5'd24) $display("FAIL reset_port: got %0d want 24", sscPort); else n_pass++;
    n_checks++;
    if (reqReady !== 1'b1) $display("FAIL reset_ready: got %0b want 1", reqReady); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++;
    if ({grant, done, errInvalid, errTimeout} !== 4'b0)
      $display("FAIL reset_pulses: got %b want 0000", {grant, done, errInvalid, errTimeout});
    else n_pass++;
  endtask

  task automatic test_settle_frame();
    int c;
    ev_t e, ex;
    bit got;
    do_request(5'd3, c);
    n_checks++;
    if (sscPort !== 5'd3) $display("FAIL settle_port_c1: got %0d want 3", sscPort); else n_pass++;
    n_checks++;
    if (reqReady !== 1'b0 || busy !== 1'b1)
      $display("FAIL settle_ready_busy: got ready=%0b busy=%0b want 0/1", reqReady, busy);
    else n_pass++;
    exp_q.push_back(mk(K_GRANT, c + SETTLE + 1, 5'd3));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL settle_grant: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    drive_frame(20, 5'd3);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL frame_done: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    n_checks++;
    if (reqReady !== 1'b0) $display("FAIL done_cycle_ready: got %0b want 0", reqReady); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (reqReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL after_done_ready: got ready=%0b busy=%0b want 1/0", reqReady, busy);
    else n_pass++;
  endtask

  task automatic test_same_port();
    int c;
    ev_t e, ex;
    bit got;
    do_request(5'd3, c);
    exp_q.push_back(mk(K_GRANT, c + 1, 5'd3));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL same_grant: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    drive_frame(3, 5'd3);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL same_done: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
  endtask

  task automatic test_invalid();
    int c;
    ev_t e, ex;
    bit got;
    logic [4:0] bad [2];
    bad[0] = 5'd25;
    bad[1] = 5'd31;
    for (int k = 0; k < 2; k++) begin
      do_request(bad[k], c);
      exp_q.push_back(mk(K_INV, c + 1, 5'd3));
      wait_event(e, got); ex = exp_q.pop_front();
      n_checks++;
      if (!got || e !== ex)
        $display("FAIL invalid_pulse_%0d: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
                 bad[k], e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
      else n_pass++;
      n_checks++;
      if (sscPort !== 5'd3 || busy !== 1'b0 || reqReady !== 1'b1)
        $display("FAIL invalid_state_%0d: got port=%0d busy=%0b ready=%0b want 3/0/1",
                 bad[k], sscPort, busy, reqReady);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int c;
    ev_t e, ex;
    bit got;
    do_request(5'd12, c);
    exp_q.push_back(mk(K_GRANT, c + SETTLE + 1, 5'd12));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL tmo_grant: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
`ifdef SSC_PORT_SEQ_TIMEOUT_EN
    exp_q.push_back(mk(K_TMO, int'(e.cyc) + TMO, 5'd12));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL tmo_pulse: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    n_checks++;
    if (reqReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL tmo_idle: got ready=%0b busy=%0b want 1/0", reqReady, busy);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL tmo_no_done: got %0d events want 0", obs_q.size());
    else n_pass++;
`else
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || reqReady !== 1'b0)
      $display("FAIL armed_wait: got busy=%0b ready=%0b want 1/0", busy, reqReady);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL armed_quiet: got %0d events want 0", obs_q.size());
    else n_pass++;
    drive_frame(2, 5'd12);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL armed_done: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int c;
    ev_t e, ex;
    bit got;
    do_request(5'd7, c);
    exp_q.push_back(mk(K_GRANT, c + SETTLE + 1, 5'd7));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL mid_grant: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    @(negedge clk);
    sscSync1 = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_active_busy: got %0b want 1", busy); else n_pass++;
    #2 rstN = 1'b0;
    #1;
    n_checks++;
    if (sscPort !== 5'd24 || busy !== 1'b0 || reqReady !== 1'b1)
      $display("FAIL mid_async_reset: got port=%0d busy=%0b ready=%0b want 24/0/1",
               sscPort, busy, reqReady);
    else n_pass++;
    sscSync1 = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL mid_no_done: got %0d events want 0", obs_q.size());
    else n_pass++;
    do_request(5'd7, c);
    n_checks++;
    if (sscPort !== 5'd7) $display("FAIL mid_reselect: got %0d want 7", sscPort); else n_pass++;
    exp_q.push_back(mk(K_GRANT, c + SETTLE + 1, 5'd7));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL mid_regrant: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    drive_frame(2, 5'd7);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL mid_done: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    ev_t e, ex;
    bit got;
    do_request(5'd7, c);
    exp_q.push_back(mk(K_GRANT, c + 1, 5'd7));
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL b2b_grant1: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    drive_frame(2, 5'd7);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL b2b_done1: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    // Request held from the done cycle; it is accepted on the first ready cycle.
    reqValid = 1'b1;
    reqPort  = 5'd10;
    @(negedge clk);
    n_checks++;
    if (reqReady !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", reqReady); else n_pass++;
    c = cyc;
    exp_q.push_back(mk(K_GRANT, c + SETTLE + 1, 5'd10));
    @(negedge clk);
    reqValid = 1'b0;
    n_checks++;
    if (sscPort !== 5'd10) $display("FAIL b2b_port: got %0d want 10", sscPort); else n_pass++;
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL b2b_grant2: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
    drive_frame(2, 5'd10);
    wait_event(e, got); ex = exp_q.pop_front();
    n_checks++;
    if (!got || e !== ex)
      $display("FAIL b2b_done2: got k=%0d cyc=%0d port=%0d seen=%0b want k=%0d cyc=%0d port=%0d",
               e.kind, e.cyc, e.port, got, ex.kind, ex.cyc, ex.port);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_settle_frame();
    test_same_port();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL spurious_events: got %0d events want 0", obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_ssc_port_sequencer
`default_nettype wire
